// File: rtl/ctr_stream_controller.sv
// ctr_stream_controller: multi-block CTR-mode stream engine (counter issue, keystream FIFO, XOR).
// Latency: one cycle from an accepted input word to m_tvalid; keystream latency is set by the core.
// Backpressure: issue is credit-limited to KS_DEPTH blocks in flight/buffered; s_tready drops while
//   the keystream FIFO is empty or the output register is held by m_tready=0.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   key_ready                       round keys valid; gates new counter-block requests
//   start, iv, num_blocks           message request; iv/num_blocks sampled when start is accepted in IDLE
//   core_tvalid/core_ready/core_block         counter block to the block-cipher core
//   core_valid/core_keystream       keystream blocks returned by the core in issue order
//   s_tvalid/s_tready/s_tdata/s_tlast         input data stream
//   m_tvalid/m_tready/m_tdata/m_tlast         output stream (s_tdata XOR keystream)
//   busy, done, error               status: not idle, one-cycle completion pulse, sticky tlast mismatch
// Optional feature macro: CTR_TLAST_CHECK_EN (tlast position checking drives error; otherwise error=0).
module ctr_stream_controller #(
  parameter int DATA_WIDTH = 256,
  parameter int CNT_W      = 32,
  parameter int KS_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  key_ready,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] iv,
  input  logic [CNT_W-1:0]      num_blocks,
  output logic                  core_tvalid,
  input  logic                  core_ready,
  output logic [DATA_WIDTH-1:0] core_block,
  input  logic                  core_valid,
  input  logic [DATA_WIDTH-1:0] core_keystream,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int AW = $clog2(KS_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] LP_DEPTH = (CW + 1)'(KS_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_iv;
  logic [CNT_W-1:0]      r_num;
  logic [CNT_W-1:0]      r_issued;
  logic [CNT_W-1:0]      r_consumed;
  logic [CW-1:0]         r_outstanding;
  logic [CW-1:0]         r_count;
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_ks_mem [KS_DEPTH];
  logic                  r_hold;
  logic                  r_m_tvalid;
  logic                  r_m_tlast;
  logic [DATA_WIDTH-1:0] r_m_tdata;
  logic                  r_done;

  logic                  w_run;
  logic [CW:0]           w_used;
  logic                  w_credit_ok;
  logic                  w_issue;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_last_word;
  logic                  w_final_out;
  logic [DATA_WIDTH-1:0] w_core_block;

  // Counter block: only the low CNT_W field advances; it wraps without carrying into the IV prefix.
  if (CNT_W < DATA_WIDTH) begin : g_split
    assign w_core_block = {r_iv[DATA_WIDTH-1:CNT_W], r_iv[CNT_W-1:0] + r_issued};
  end else begin : g_full
    assign w_core_block = r_iv + r_issued;
  end

  assign w_run       = (r_state == ST_RUN);
  // Blocks in flight plus blocks buffered never exceed the FIFO depth, so returns cannot overflow.
  assign w_used      = {1'b0, r_outstanding} + {1'b0, r_count};
  assign w_credit_ok = (w_used < LP_DEPTH);
  // r_hold keeps a presented request alive even if key_ready drops before the core takes it.
  assign core_tvalid = w_run && (r_hold || (key_ready && (r_issued < r_num) && w_credit_ok));
  assign core_block  = w_core_block;
  assign w_issue     = core_tvalid && core_ready;
  // Returns with nothing outstanding are stale (e.g. issued before a reset) and are dropped.
  assign w_push      = w_run && core_valid && (r_outstanding != '0);
  assign s_tready    = w_run && (r_count != '0) && (r_consumed < r_num) && (!r_m_tvalid || m_tready);
  assign w_pop       = s_tvalid && s_tready;
  assign w_last_word = (r_consumed == r_num - 1'b1);
  assign w_final_out = w_run && (r_consumed == r_num) && r_m_tvalid && m_tready;

  assign m_tvalid = r_m_tvalid;
  assign m_tdata  = r_m_tdata;
  assign m_tlast  = r_m_tlast;
  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;

  // Keystream storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (w_push) r_ks_mem[r_wr_ptr] <= core_keystream;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_iv          <= '0;
      r_num         <= '0;
      r_issued      <= '0;
      r_consumed    <= '0;
      r_outstanding <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_hold        <= 1'b0;
      r_m_tvalid    <= 1'b0;
      r_m_tlast     <= 1'b0;
      r_m_tdata     <= '0;
      r_done        <= 1'b0;
    end else begin
      r_hold        <= core_tvalid && !core_ready;
      r_outstanding <= r_outstanding + CW'(w_issue) - CW'(w_push);
      r_count       <= r_count + CW'(w_push) - CW'(w_pop);
      r_done        <= 1'b0;
      if (w_issue) r_issued <= r_issued + 1'b1;
      if (w_push)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_consumed <= r_consumed + 1'b1;
        r_m_tdata  <= s_tdata ^ r_ks_mem[r_rd_ptr];
        r_m_tvalid <= 1'b1;
        r_m_tlast  <= w_last_word;
      end else if (m_tready) begin
        r_m_tvalid <= 1'b0;
        r_m_tlast  <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_iv       <= iv;
            r_num      <= num_blocks;
            r_issued   <= '0;
            r_consumed <= '0;
            r_state    <= (num_blocks == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_final_out) r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef CTR_TLAST_CHECK_EN
  logic r_error;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_error <= 1'b0;
    end else if (r_state == ST_IDLE && start) begin
      r_error <= 1'b0;
    end else if (w_pop && (s_tlast != w_last_word)) begin
      r_error <= 1'b1;
    end
  end
  assign error = r_error;
`else
  logic w_unused_tlast;
  assign w_unused_tlast = s_tlast;
  assign error = 1'b0;
`endif

endmodule
